// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative HI/LO multiply/divide unit, one bit per cycle
//
// Purpose: MIPS-style HI/LO multiply/divide engine. A multiply produces the
// 2W-bit product as {hi,lo}. A divide produces the quotient in lo and the
// remainder in hi. Signed operations run on operand magnitudes, and the sign
// is fixed up in a final FIX cycle.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset; aborts any operation in flight
//   start  - begin an operation (taken only while idle)
//   op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b   - operands (rs, rt)
//   mthi   - write wdata to hi while idle
//   mtlo   - write wdata to lo while idle
//   wdata  - data for mthi/mtlo
//   busy   - operation in progress
//   done   - one-cycle pulse after an operation has updated hi/lo
//   hi, lo - architectural HI/LO registers
module muldiv_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic           r_is_div;
  logic [W-1:0]   r_a;       // raw dividend, returned in hi on divide by zero
  logic [W-1:0]   r_opnd;    // multiplicand or divisor magnitude
  logic [2*W-1:0] r_acc;     // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic           r_neg_q;   // negate product / quotient at FIX
  logic           r_neg_r;   // negate remainder at FIX
  logic           r_done;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;

  logic           w_signed_in;
  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;
  logic [W:0]     w_div_shift;
  logic [W:0]     w_div_diff;
  logic [2*W-1:0] w_div_next;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quo_mag;
  logic [W-1:0]   w_rem_mag;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Operand magnitudes at issue. The most-negative value maps onto itself,
  // and that bit pattern is exactly its unsigned magnitude.
  assign w_signed_in = ~op[0];
  assign w_abs_a     = (w_signed_in && a[W-1]) ? -a : a;
  assign w_abs_b     = (w_signed_in && b[W-1]) ? -b : b;

  // Shift-add multiply step. The upper half is summed one bit wider so that
  // the carry can shift back into the product.
  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

  // Restoring divide step. Shift the next dividend bit into the remainder and
  // try to subtract. The shifted remainder can reach 2*divisor-1, which needs
  // W+1 bits. A restored value is below the divisor, so W bits hold it.
  assign w_div_shift = r_acc[2*W-1:W-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_next  = w_div_diff[W] ? {w_div_shift[W-1:0], r_acc[W-2:0], 1'b0}
                                     : {w_div_diff[W-1:0],  r_acc[W-2:0], 1'b1};

  assign w_prod    = r_neg_q ? -r_acc : r_acc;
  assign w_quo_mag = r_acc[W-1:0];
  assign w_rem_mag = r_acc[2*W-1:W];
  assign w_quo     = r_neg_q ? -w_quo_mag : w_quo_mag;
  assign w_rem     = r_neg_r ? -w_rem_mag : w_rem_mag;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == LAST) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_a      <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // start wins over mthi/mtlo on the same edge
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_a      <= a;
            r_neg_q  <= w_signed_in & (a[W-1] ^ b[W-1]);
            r_neg_r  <= (op == 2'b10) & a[W-1];
            if (op[1]) begin
              r_opnd <= w_abs_b;
              r_acc  <= {{W{1'b0}}, w_abs_a};
            end else begin
              r_opnd <= w_abs_a;
              r_acc  <= {{W{1'b0}}, w_abs_b};
            end
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_done <= 1'b1;
          r_cnt  <= '0;
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_opnd == '0) begin
            // a zero divisor magnitude means b was zero
            r_hi <= r_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  int pulses;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  always #5 clk = ~clk;

  muldiv_unit #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int l);
    l = lat0;
    while (done !== 1'b1 && l < 200) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
    int l;
    start_op(o, x, y);
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    chk({tag, "_hold_hi"}, 64'(hi), 64'(m_hi));
    wait_done(0, l);
    chk({tag, "_latency"}, 64'(l), 64'(W + 1));
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    m_hi = eh; m_lo = el;
    @(negedge clk);
    chk({tag, "_done_once"}, 64'(done), 64'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));

    // arithmetic vectors
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("mult_m5xm6", 2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'h1E);
    run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("div_m5by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("multu_shift", 2'b01, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780);

    // second start while busy is dropped
    start_op(2'b01, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    op = 2'b01; a = 32'd100; b = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, lat);
    chk("ignore_latency", 64'(lat), 64'(W + 1));
    chk("ignore_hi", 64'(hi), 64'(0));
    chk("ignore_lo", 64'(lo), 64'(42));
    m_hi = '0; m_lo = 32'd42;

    // back-to-back issue on the done cycle
    start_op(2'b11, 32'd100, 32'd7);
    chk("b2b_done_low", 64'(done), 64'(0));
    chk("b2b_busy", 64'(busy), 64'(1));
    wait_done(0, lat);
    chk("b2b_latency", 64'(lat), 64'(W + 1));
    chk("b2b_hi", 64'(hi), 64'(2));
    chk("b2b_lo", 64'(lo), 64'(14));
    m_hi = 32'd2; m_lo = 32'd14;
    count_pulses(40, pulses);
    chk("ignore_no_extra_done", 64'(pulses), 64'(0));

    // mthi / mtlo in idle
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'(32'h1234));
    chk("mthi_lo_kept", 64'(lo), 64'(m_lo));
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo_hi", 64'(hi), 64'(32'hA5A5_A5A5));
    chk("mthilo_lo", 64'(lo), 64'(32'hA5A5_A5A5));
    m_hi = 32'hA5A5_A5A5; m_lo = 32'hA5A5_A5A5;

    // mtlo while busy is ignored
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_busy_lo", 64'(lo), 64'(m_lo));
    wait_done(1, lat);
    chk("mtlo_busy_latency", 64'(lat), 64'(W + 1));
    chk("mtlo_busy_res_lo", 64'(lo), 64'(32'hFFFF_FFEB));
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFEB;
    @(negedge clk);

    // start has priority over mthi on the same edge
    mthi = 1'b1; wdata = 32'h5555_5555;
    start_op(2'b01, 32'd3, 32'd5);
    mthi = 1'b0;
    chk("prio_hi_kept", 64'(hi), 64'(m_hi));
    wait_done(0, lat);
    chk("prio_hi", 64'(hi), 64'(0));
    chk("prio_lo", 64'(lo), 64'(15));
    m_hi = '0; m_lo = 32'd15;
    @(negedge clk);

    // reset mid-run aborts without a done pulse
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    m_hi = '0; m_lo = '0;
    count_pulses(40, pulses);
    chk("abort_no_done", 64'(pulses), 64'(0));
    run_op("after_abort", 2'b00, 32'd9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFEE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter W, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled at each rising edge.
REQ-005 SHALL have port op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have port a  input  W  multiplicand or dividend (rs).
REQ-007 SHALL have port b  input  W  multiplier or divisor (rt).
REQ-008 SHALL have port mthi  input  1  write wdata into HI.
REQ-009 SHALL have port mtlo  input  1  write wdata into LO.
REQ-010 SHALL have port wdata  input  W  data for mthi/mtlo.
REQ-011 SHALL have port busy  output  1  operation in progress; start ignored while high.
REQ-012 SHALL have port done  output  1  one-cycle pulse: HI/LO just updated by an operation.
REQ-013 SHALL have port hi  output  W  HI register, registered output.
REQ-014 SHALL have port lo  output  W  LO register, registered output.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> FIX -> IDLE; busy = (state != IDLE).
REQ-016 SHALL accept start only in IDLE; on that edge, latch op, a and b, and enter RUN with iteration counter = 0.
REQ-017 SHALL perform one iteration per cycle in RUN: shift-add for multiply, restoring shift-subtract for divide, using operand magnitudes for signed ops.
REQ-018 SHALL leave RUN for FIX after exactly W RUN edges.
REQ-019 SHALL, on the FIX edge, apply sign correction, write hi/lo, pulse done high for the following cycle, and return to IDLE.
REQ-020 SHALL therefore have latency W+1 edges: start accepted at edge 0, busy high cycles 1..W+1, hi/lo valid and done=1 in cycle W+2 with busy=0.
REQ-021 SHALL for MULT/MULTU, place the 2W-bit product as {hi,lo}; signed product negated when sign(a) != sign(b).
REQ-022 SHALL for DIV/DIVU, place the quotient in lo and the remainder in hi; signed quotient negative iff sign(a) != sign(b), remainder takes sign of a.
REQ-023 SHALL for divide by zero (any divide op), produce lo = all ones, hi = a.
REQ-024 SHALL for DIV with a = most-negative and b = -1, produce lo = most-negative, hi = 0.
REQ-025 SHALL ignore start while busy; no queuing.
REQ-026 SHALL accept a new start in the cycle done is high (back-to-back issue).
REQ-027 SHALL in IDLE, write wdata to hi on mthi and to lo on mtlo at the edge; both may be asserted together.
REQ-028 SHALL ignore mthi/mtlo while busy, and when start is accepted on the same edge (start has priority).
REQ-029 SHALL hold hi/lo unchanged during RUN; intermediate values stay in internal registers.

Reset
REQ-030 SHALL on reset=1 at an edge: state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, counter = 0.
REQ-031 SHALL give reset priority over start, mthi and mtlo, and SHALL abort any in-flight operation with no hi/lo update and no done pulse.

Verification
REQ-032 SHALL verify MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after W+1 edges, hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
REQ-033 SHALL verify MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 SHALL verify DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100; DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-035 SHALL verify start pulsed at cycles 1 and 5 with different operands -> only the first result is produced; start on the done cycle -> second operation completes W+1 edges later.
REQ-036 SHALL verify mthi=1, wdata=0x1234 in IDLE -> hi=0x1234 next cycle; mtlo while busy -> lo unchanged.
REQ-037 SHALL verify reset asserted mid-RUN -> busy=0, hi=lo=0 next cycle, no done pulse; a new start then completes normally.
